// File: rtl/timer_interrupt.sv
// timer_interrupt: compare-match detection, interrupt enable (TIER) and
// write-1-to-clear interrupt status (TISR) for the 64-bit APB timer.
// Drives the level-sensitive timer interrupt line to the core.
module timer_interrupt #(
  parameter logic [31:0] ADDR_TIER = 32'h14,
  parameter logic [31:0] ADDR_TISR = 32'h18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic [63:0] cnt,
  input  logic [63:0] tcmp,
  output logic        int_en,
  output logic        int_st,
  output logic        tim_int,
  output logic [31:0] tier,
  output logic [31:0] tisr
);

  logic match_raw;
  logic set_ev;
  logic tier_wr;
  logic tisr_clr;

  logic int_en_d, int_en_q;
  logic int_st_d, int_st_q;
  logic match_d,  match_q;

  // Decode writes, detect the rising edge of the match, compute next state.
  // A set event outranks a clear on the same edge so no interrupt is lost.
  always_comb begin
    match_raw = (cnt == tcmp);
    set_ev    = match_raw & ~match_q;
    tier_wr   = wr_en && (addr == ADDR_TIER);
    tisr_clr  = wr_en && (addr == ADDR_TISR) && wdata[0];

    match_d  = match_raw;
    int_en_d = int_en_q;
    int_st_d = int_st_q;

    if (tier_wr) begin
      int_en_d = wdata[0];
    end
    if (tisr_clr) begin
      int_st_d = 1'b0;
    end
    if (set_ev) begin
      int_st_d = 1'b1;
    end
  end

  // State registers; match_q clears on reset so a match held across reset
  // release raises status on the first edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_en_q <= 1'b0;
      int_st_q <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      int_en_q <= int_en_d;
      int_st_q <= int_st_d;
      match_q  <= match_d;
    end
  end

  // Outputs come straight from registers, so tim_int is glitch-free.
  assign int_en  = int_en_q;
  assign int_st  = int_st_q;
  assign tim_int = int_st_q & int_en_q;
  assign tier    = {31'b0, int_en_q};
  assign tisr    = {31'b0, int_st_q};

endmodule
